// File: rtl/ifu_fetch.sv
// ifu_fetch -- single-outstanding instruction fetch unit.
//
// Takes a fetch address from the PC register, issues one memory read and
// waits for the response. It then presents the instruction to the decoder
// and holds it until the decoder accepts it. Misaligned addresses fault
// without touching memory. A missing response times out. A flush (jump or
// branch redirect) abandons the current fetch. If a request has already
// been handed to memory, the flush drains the response that will come back.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// 1. Once valid is raised, it stays up and its payload stays stable until
// that transfer happens or a flush/reset withdraws it. mem_rsp_valid is a
// single-cycle pulse with no back-pressure.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   pc_addr/valid   fetch address offered by the PC register
//   pc_advance      one-cycle pulse after the decoder takes an instruction
//   flush           redirect; discards the fetch in progress
//   mem_req_*       read request channel (valid/ready, address)
//   mem_rsp_*       read response (valid pulse, data, bus error)
//   inst_valid/ready, inst, inst_pc, fetch_fault
//                   instruction channel to the decoder
//                   fault: 0 none, 1 misaligned, 2 bus error, 3 timeout
//   fsm_state       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD, 4 DRAIN)
//
// TIMEOUT_CYCLES is the number of WAIT/DRAIN cycles without a response
// before the fetch gives up. Legal range is 2..65535.

module ifu_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_advance,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  fetch_fault,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  localparam logic [1:0] F_NONE  = 2'd0;
  localparam logic [1:0] F_ALIGN = 2'd1;
  localparam logic [1:0] F_BUS   = 2'd2;
  localparam logic [1:0] F_TMO   = 2'd3;

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        timed_out;
  logic        cnt_step;

  // A flush on the very cycle the timeout fires still bumps the counter
  // before DRAIN looks at it. So the limit is checked with >= rather than
  // ==, which keeps DRAIN from waiting for a wrap that never comes.
  assign timed_out = (cnt >= TMO_LAST);
  // Counts only silent cycles. The counter saturates instead of wrapping.
  assign cnt_step  = !mem_rsp_valid && (cnt != CNT_MAX);

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 16'd0;
      pc_advance    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      inst_valid    <= 1'b0;
      inst          <= 32'd0;
      inst_pc       <= 32'd0;
      fetch_fault   <= F_NONE;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pc_valid && !flush) begin
            inst_pc <= pc_addr;
            if (pc_addr[1:0] == 2'b00) begin
              mem_req_addr  <= pc_addr;
              mem_req_valid <= 1'b1;
              state         <= S_REQ;
            end else begin
              inst        <= 32'd0;
              fetch_fault <= F_ALIGN;
              inst_valid  <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end

        S_REQ: begin
          if (mem_req_ready) begin
            // Memory owns the request now, so the response must be waited
            // for (or drained) even if a flush arrives on this cycle.
            mem_req_valid <= 1'b0;
            cnt           <= 16'd0;
            state         <= flush ? S_DRAIN : S_WAIT;
          end else if (flush) begin
            mem_req_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (cnt_step) begin
            cnt <= cnt + 16'd1;
          end
          if (flush) begin
            state <= S_DRAIN;
          end else if (mem_rsp_valid) begin
            inst        <= mem_rsp_data;
            fetch_fault <= mem_rsp_err ? F_BUS : F_NONE;
            inst_valid  <= 1'b1;
            state       <= S_HOLD;
          end else if (timed_out) begin
            inst        <= 32'd0;
            fetch_fault <= F_TMO;
            inst_valid  <= 1'b1;
            state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (flush) begin
            inst_valid <= 1'b0;
            state      <= S_IDLE;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            pc_advance <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (cnt_step) begin
            cnt <= cnt + 16'd1;
          end
          if (mem_rsp_valid || timed_out) begin
            state <= S_IDLE;
          end
        end

        default: begin
          mem_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- self-checking bench for ifu_fetch (TIMEOUT_CYCLES = 4).
// A transaction-level model predicts every output each cycle. Directed
// sequences pin the model to literal values. A randomized phase then
// exercises flush, back-pressure, errors, timeouts, reset and stray responses.

module tb_ifu_fetch;

  localparam int TMO = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_advance;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  fetch_fault;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  ifu_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .pc_advance(pc_advance), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .fetch_fault(fetch_fault), .fsm_state(fsm_state)
  );

  // ---------------- counters / check helper ----------------
  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A fetch is a transaction: offered to memory, then owed a response
  // (either to deliver or to throw away), then parked for the decoder.
  bit          m_offered;   // request on the bus, not yet accepted
  bit          m_owed;      // accepted; response will be delivered
  bit          m_discard;   // accepted; response will be thrown away
  bit          m_parked;    // instruction parked for the decoder
  bit          m_adv;
  bit          m_hs;        // handshake happened at the last edge
  int          m_silent;    // silent cycles since the handshake
  logic [31:0] m_addr, m_inst, m_pc;
  logic [1:0]  m_fault;

  initial begin
    m_offered = 0; m_owed = 0; m_discard = 0; m_parked = 0; m_adv = 0;
    m_hs = 0; m_silent = 0; m_addr = 0; m_inst = 0; m_pc = 0; m_fault = 0;
  end

  always @(posedge clk) begin
    m_hs  = !rst && m_offered && mem_req_ready;
    m_adv = 0;
    if (rst) begin
      m_offered = 0; m_owed = 0; m_discard = 0; m_parked = 0; m_silent = 0;
      m_addr = 0; m_inst = 0; m_pc = 0; m_fault = 0;
    end else if (m_offered) begin
      m_offered = 0;
      if (mem_req_ready) begin
        m_silent = 0;
        if (flush) m_discard = 1; else m_owed = 1;
      end else if (!flush) begin
        m_offered = 1;
      end
    end else if (m_owed) begin
      if (flush) begin
        m_owed = 0; m_discard = 1;
        if (!mem_rsp_valid) m_silent++;
      end else if (mem_rsp_valid) begin
        m_owed = 0; m_parked = 1; m_inst = mem_rsp_data;
        m_fault = mem_rsp_err ? 2'd2 : 2'd0;
      end else if (m_silent + 1 >= TMO) begin
        m_owed = 0; m_parked = 1; m_inst = 0; m_fault = 2'd3;
      end else begin
        m_silent++;
      end
    end else if (m_discard) begin
      if (mem_rsp_valid || m_silent + 1 >= TMO) m_discard = 0;
      else m_silent++;
    end else if (m_parked) begin
      if (flush) m_parked = 0;
      else if (inst_ready) begin m_parked = 0; m_adv = 1; end
    end else if (pc_valid && !flush) begin
      m_pc = pc_addr;
      if (pc_addr % 4 == 0) begin
        m_offered = 1; m_addr = pc_addr;
      end else begin
        m_parked = 1; m_inst = 0; m_fault = 2'd1;
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    check("cyc_req_valid",  {31'd0, mem_req_valid}, {31'd0, m_offered});
    check("cyc_req_addr",   mem_req_addr, m_addr);
    check("cyc_inst_valid", {31'd0, inst_valid}, {31'd0, m_parked});
    check("cyc_inst",       inst, m_inst);
    check("cyc_inst_pc",    inst_pc, m_pc);
    check("cyc_fault",      {30'd0, fetch_fault}, {30'd0, m_fault});
    check("cyc_pc_advance", {31'd0, pc_advance}, {31'd0, m_adv});
  end

  // ---------------- driver tasks ----------------
  int rsp_due = -1;

  task automatic quiet_inputs();
    rst = 0; pc_addr = 0; pc_valid = 0; flush = 0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0; inst_ready = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_req_valid"},  {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_req_addr"},   mem_req_addr, 32'd0);
    check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_inst"},       inst, 32'd0);
    check({tag, "_inst_pc"},    inst_pc, 32'd0);
    check({tag, "_fault"},      {30'd0, fetch_fault}, 32'd0);
    check({tag, "_pc_advance"}, {31'd0, pc_advance}, 32'd0);
  endtask

  task automatic rand_cycle();
    logic [31:0] a;
    @(negedge clk);
    rst      = ($urandom_range(0, 299) == 0);
    a        = $urandom;
    if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
    pc_addr  = a;
    pc_valid = ($urandom_range(0, 3) != 0);
    flush    = ($urandom_range(0, 15) == 0);
    mem_req_ready = ($urandom_range(0, 2) != 0);
    inst_ready    = ($urandom_range(0, 2) != 0);
    if (m_hs) rsp_due = $urandom_range(0, 5);
    mem_rsp_data = $urandom;
    if (rsp_due == 0) begin
      mem_rsp_valid = 1;
      mem_rsp_err   = ($urandom_range(0, 7) == 0);
      rsp_due       = -1;
    end else begin
      if (rsp_due > 0) rsp_due--;
      mem_rsp_valid = ($urandom_range(0, 19) == 0);
      mem_rsp_err   = ($urandom_range(0, 1) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    quiet_inputs();
    rst = 1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 0;

    // normal fetch, response in the second WAIT cycle
    pc_addr = 32'h8000_0000; pc_valid = 1; mem_req_ready = 1;
    tick();
    check("norm_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("norm_req_addr", mem_req_addr, 32'h8000_0000);
    pc_valid = 0;
    tick();
    check("norm_req_drop", {31'd0, mem_req_valid}, 32'd0);
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0413;
    tick();
    check("norm_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("norm_inst", inst, 32'h0000_0413);
    check("norm_inst_pc", inst_pc, 32'h8000_0000);
    check("norm_fault", {30'd0, fetch_fault}, 32'd0);
    mem_rsp_valid = 0; inst_ready = 1;
    tick();
    check("norm_adv", {31'd0, pc_advance}, 32'd1);
    inst_ready = 0;
    tick();
    check("norm_adv_once", {31'd0, pc_advance}, 32'd0);

    // misaligned: no request; then flush in HOLD beats inst_ready
    pc_addr = 32'h8000_0002; pc_valid = 1;
    tick();
    check("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("mis_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("mis_fault", {30'd0, fetch_fault}, 32'd1);
    check("mis_inst", inst, 32'd0);
    check("mis_inst_pc", inst_pc, 32'h8000_0002);
    pc_valid = 0; flush = 1; inst_ready = 1;
    tick();
    check("hold_flush_valid", {31'd0, inst_valid}, 32'd0);
    check("hold_flush_adv", {31'd0, pc_advance}, 32'd0);
    flush = 0; inst_ready = 0;

    // bus error at best-case latency; a response during REQ is ignored
    pc_addr = 32'h8000_0004; pc_valid = 1; mem_req_ready = 1;
    tick();
    pc_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF_FFFF;
    tick();
    check("lat_wait_valid", {31'd0, inst_valid}, 32'd0);
    mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_data = 32'h1234_5678;
    tick();
    check("berr_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("berr_fault", {30'd0, fetch_fault}, 32'd2);
    check("berr_inst", inst, 32'h1234_5678);
    mem_rsp_valid = 0; mem_rsp_err = 0; inst_ready = 1;
    tick();
    inst_ready = 0;

    // timeout exactly TMO cycles after WAIT, then 5 cycles of back-pressure
    pc_addr = 32'h8000_0008; pc_valid = 1;
    tick();
    pc_valid = 0;
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo_early", {31'd0, inst_valid}, 32'd0);
    end
    tick();
    check("tmo_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("tmo_fault", {30'd0, fetch_fault}, 32'd3);
    check("tmo_inst", inst, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_inst_pc", inst_pc, 32'h8000_0008);
      check("bp_fault", {30'd0, fetch_fault}, 32'd3);
      check("bp_adv", {31'd0, pc_advance}, 32'd0);
    end
    inst_ready = 1;
    tick();
    check("bp_release_adv", {31'd0, pc_advance}, 32'd1);
    inst_ready = 0;

    // flush in REQ without ready drops the request
    pc_addr = 32'h8000_0020; pc_valid = 1; mem_req_ready = 0;
    tick();
    check("rflush_req_on", {31'd0, mem_req_valid}, 32'd1);
    pc_valid = 0; flush = 1;
    tick();
    check("rflush_req_off", {31'd0, mem_req_valid}, 32'd0);
    flush = 0; mem_req_ready = 1;
    tick();
    check("rflush_idle", {31'd0, mem_req_valid}, 32'd0);

    // flush in WAIT, response 2 cycles later is discarded
    pc_addr = 32'h8000_000C; pc_valid = 1;
    tick();
    pc_valid = 0;
    tick();
    flush = 1;
    tick();
    check("drain_valid0", {31'd0, inst_valid}, 32'd0);
    flush = 0;
    tick();
    check("drain_valid1", {31'd0, inst_valid}, 32'd0);
    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0_BAD0;
    tick();
    check("drain_done_valid", {31'd0, inst_valid}, 32'd0);
    mem_rsp_valid = 0;
    pc_addr = 32'h8000_0010; pc_valid = 1;
    tick();
    check("next_req_addr", mem_req_addr, 32'h8000_0010);
    pc_valid = 0;
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'h0010_0093;
    tick();
    check("next_inst", inst, 32'h0010_0093);
    check("next_inst_pc", inst_pc, 32'h8000_0010);
    check("next_inst_valid", {31'd0, inst_valid}, 32'd1);
    mem_rsp_valid = 0; inst_ready = 1;
    tick();
    inst_ready = 0;

    // reset in WAIT, then a late response arrives in IDLE
    pc_addr = 32'h8000_0014; pc_valid = 1;
    tick();
    pc_valid = 0;
    tick();
    rst = 1;
    tick();
    check_all_zero("rst_wait");
    rst = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0055;
    tick();
    check("late_rsp_valid", {31'd0, inst_valid}, 32'd0);
    check("late_rsp_req", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 0;

    // randomized phase
    rsp_due = -1;
    for (int c = 0; c < 4000; c++) rand_cycle();

    quiet_inputs();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT/DRAIN cycles spent waiting for a memory response before a timeout is declared; legal range is 2..65535.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pc_addr  in  32  fetch address from the PC register.
REQ-005 pc_valid  in  1  pc_addr is valid this cycle.
REQ-006 pc_advance  out  1  one-cycle pulse when the decoder accepts an instruction; the PC may then update.
REQ-007 flush  in  1  jump/branch redirect; the current fetch is discarded.
REQ-008 mem_req_valid  out  1  memory read request is valid.
REQ-009 mem_req_ready  in  1  memory accepts the request.
REQ-010 mem_req_addr  out  32  request address.
REQ-011 mem_rsp_valid  in  1  response is valid (single cycle).
REQ-012 mem_rsp_data  in  32  instruction word returned by memory.
REQ-013 mem_rsp_err  in  1  bus error flag, qualified by mem_rsp_valid.
REQ-014 inst_valid  out  1  instruction is available to the decoder.
REQ-015 inst_ready  in  1  decoder accepts the instruction.
REQ-016 inst  out  32  fetched instruction word.
REQ-017 inst_pc  out  32  address the instruction was fetched from.
REQ-018 fetch_fault  out  2  fault code: 0 none, 1 misaligned, 2 bus error, 3 timeout.

Function
REQ-019 The FSM SHALL have five states: IDLE, REQ, WAIT, HOLD, DRAIN; all outputs SHALL be driven directly from registers.
REQ-020 IDLE: on pc_valid with flush=0 and pc_addr[1:0]==0, the block SHALL latch pc_addr into mem_req_addr and inst_pc, then go to REQ.
REQ-021 IDLE: on pc_valid with flush=0 and pc_addr[1:0]!=0, the block SHALL go directly to HOLD with fetch_fault=1, inst=0 and inst_pc=pc_addr, and SHALL issue no memory request.
REQ-022 REQ: mem_req_valid SHALL be 1 and mem_req_addr SHALL stay stable until mem_req_ready; on a cycle with mem_req_ready=1, the block SHALL go to WAIT and clear the timeout counter.
REQ-023 WAIT: the counter SHALL increment each cycle that mem_rsp_valid=0.
- On mem_rsp_valid: go to HOLD; inst=mem_rsp_data; fetch_fault=2 if mem_rsp_err, else 0.
- On counter==TIMEOUT_CYCLES-1 with no response: go to HOLD with fetch_fault=3 and inst=0.
REQ-024 HOLD: inst_valid SHALL be 1 and inst, inst_pc and fetch_fault SHALL be stable; on inst_ready=1, pc_advance SHALL pulse in the next cycle and the FSM SHALL go to IDLE.
REQ-025 mem_rsp_valid SHALL be ignored in IDLE, REQ and HOLD.
REQ-026 Flush takes priority over every other event; its effect depends on state:
- IDLE: stay in IDLE.
- REQ with mem_req_ready=0: go to IDLE and drop the request.
- REQ with mem_req_ready=1 in the same cycle: go to DRAIN.
- WAIT: go to DRAIN.
- HOLD: go to IDLE; no pc_advance, even if inst_ready=1 in the same cycle.
REQ-027 DRAIN: inst_valid SHALL be 0; the block SHALL go to IDLE on mem_rsp_valid (data discarded) or on timeout; the counter SHALL keep running from its current value; flush in DRAIN SHALL have no additional effect.
REQ-028 Best-case latency from pc_valid accepted in cycle N to inst_valid is 3 cycles: REQ in N+1 (ready=1), WAIT in N+2 (rsp_valid=1), HOLD in N+3.
REQ-029 At most one memory request SHALL be outstanding; mem_req_valid SHALL be 0 in every state except REQ.
REQ-030 The timeout counter SHALL be 16 bits wide and SHALL saturate, never wrap.
REQ-031 pc_advance SHALL never be asserted for more than one cycle per accepted instruction.

Reset
REQ-032 While rst=1 at posedge clk, the state SHALL become IDLE, and mem_req_valid, inst_valid and pc_advance SHALL be 0.
REQ-033 During reset, mem_req_addr, inst, inst_pc and the counter SHALL be 0 and fetch_fault SHALL be 0.
REQ-034 Reset mid-fetch (REQ, WAIT or DRAIN) SHALL abandon the transaction; a late mem_rsp_valid arriving in IDLE afterwards SHALL be ignored.

Verification
REQ-035 Normal fetch: pc_addr=0x80000000, pc_valid=1, mem_req_ready=1, response 0x00000413 after 2 cycles, inst_ready=1 -> inst=0x00000413, inst_pc=0x80000000, fault=0, then one pc_advance pulse.
REQ-036 Misaligned address: pc_addr=0x80000002 -> no mem_req_valid, HOLD with fetch_fault=1, inst=0.
REQ-037 Bus error: response with mem_rsp_err=1 -> inst_valid=1, fetch_fault=2.
REQ-038 Timeout: TIMEOUT_CYCLES=4, no response -> HOLD with fetch_fault=3 exactly 4 cycles after WAIT is entered.
REQ-039 Flush in WAIT, response 2 cycles later -> DRAIN, response discarded, inst_valid never asserted, IDLE afterwards; the next fetch of 0x80000010 returns its own data.
REQ-040 Backpressure then reset: HOLD with inst_ready=0 for 5 cycles keeps inst stable and pc_advance=0; rst asserted in WAIT -> IDLE with all outputs 0 in the next cycle.
